// File: rtl/multicycle_adder_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_adder_pkg
//   Shared definitions for the chunked multicycle adder/subtractor.
//   - state_t   : FSM state encoding (IDLE, RUN, DONE)
//   - idx_width : width of the chunk index counter for a given chunk count
// ----------------------------------------------------------------------------
package multicycle_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-chunk configuration still needs a 1-bit index so the
   // counter and its comparisons stay well formed.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   One-bit full adder.
//   Ports: sum  - a ^ b ^ cin
//          cout - carry out
//          a, b - operand bits
//          cin  - carry in
// ----------------------------------------------------------------------------
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multicycle_adder_chunk.sv
// ----------------------------------------------------------------------------
// adder_chunk
//   Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
//   This is the only arithmetic path in the multicycle adder, so CHUNK sets
//   the critical path length.
//   Ports: a, b - CHUNK-bit operands
//          cin  - carry into bit 0
//          sum  - CHUNK-bit sum
//          cout - carry out of bit CHUNK-1
// ----------------------------------------------------------------------------
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .sum  (sum[i]),
         .cout (c[i+1]),
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i])
      );
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// ----------------------------------------------------------------------------
// multicycle_adder
//   WIDTH-bit adder/subtractor that adds CHUNK bits per clock, carrying
//   between chunks through a registered carry. WIDTH must be a multiple of
//   CHUNK; the operation spends NCHUNK = WIDTH/CHUNK cycles in RUN.
//
//   Ports:
//     clk       - system clock, rising edge
//     reset     - synchronous active-high reset; aborts any operation
//     start     - request, sampled only in IDLE
//     sub       - 0: A+B+carry_in, 1: A-B (carry_in ignored)
//     A, B      - operands, latched with start
//     carry_in  - initial carry in add mode, latched with start
//     busy      - high while in RUN
//     done      - one-cycle pulse, result valid from this cycle
//     sum       - registered result, held until the next done
//     carry_out - carry out of the MSB (sub mode: 1 = no borrow)
//     overflow  - two's-complement signed overflow
// ----------------------------------------------------------------------------
module multicycle_adder
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int             NCHUNK = WIDTH / CHUNK;
   localparam int             IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0]  LAST   = IW'(NCHUNK - 1);

   state_t state, state_nx;

   // Latched operation: A and the effective B (already inverted for
   // subtract), so RUN never looks at the input ports again.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work;     // partial sum, filled chunk by chunk
   logic             carry_q;  // carry into the current chunk
   logic [IW-1:0]    idx;      // chunk being processed

   logic [CHUNK-1:0] a_ch, b_ch, s_ch;
   logic             c_ch;
   logic [WIDTH-1:0] work_nx;
   logic             ovf_nx;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (idx == LAST) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Chunk datapath
   // ------------------------------------------------------------------
   assign a_ch = a_q[idx*CHUNK +: CHUNK];
   assign b_ch = b_q[idx*CHUNK +: CHUNK];

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_ch),
      .b    (b_ch),
      .cin  (carry_q),
      .sum  (s_ch),
      .cout (c_ch)
   );

   // Working value with the current chunk merged in. On the last chunk
   // this is the complete result, so the result registers load from it
   // directly and never see a partial sum.
   always_comb begin
      work_nx = work;
      work_nx[idx*CHUNK +: CHUNK] = s_ch;
   end

   // Same-sign operands producing an opposite-sign result.
   assign ovf_nx = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (work_nx[WIDTH-1] != a_q[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         work      <= '0;
         carry_q   <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtract is A + ~B + 1; the +1 rides in as carry.
                  a_q     <= A;
                  b_q     <= sub ? ~B : B;
                  carry_q <= sub ? 1'b1 : carry_in;
                  work    <= '0;
                  idx     <= '0;
               end
            end
            RUN: begin
               work    <= work_nx;
               carry_q <= c_ch;
               idx     <= idx + 1'b1;
               if (idx == LAST) begin
                  sum       <= work_nx;
                  carry_out <= c_ch;
                  overflow  <= ovf_nx;
                  idx       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
